// File: rtl/sgdmac_data_reader.sv
// Source-side AXI4 read engine: INCR bursts per segment into a FIFO, drained as a valid/ready word stream.
// Latency: start->arvalid 1 cycle, R beat->data_valid 1 cycle; AR is withheld until FIFO space covers the whole burst.
// Optional macro SGDMAC_RD_4KB_SPLIT_EN splits bursts at 4 KB boundaries.
module sgdmac_data_reader #(
  parameter int DATA_SIZE     = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [15:0]          byte_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [31:0]          araddr_o,
  output logic [3:0]           arlen_o,
  output logic [2:0]           arsize_o,
  output logic [1:0]           arburst_o,
  output logic                 arvalid_o,
  input  logic                 arready_i,
  input  logic [DATA_SIZE-1:0] rdata_i,
  input  logic [1:0]           rresp_i,
  input  logic                 rlast_i,
  input  logic                 rvalid_i,
  output logic                 rready_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic [DATA_SIZE-1:0] data_data_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_addr;
  logic [13:0]           r_words_left;
  logic                  r_error;
  logic                  r_done;
  logic [DATA_SIZE-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_start;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ar_hs;
  logic                  w_space_ok;
  logic                  w_drain_done;
  logic [13:0]           w_blen;
  logic [13:0]           w_free;
  logic                  w_unused;

  assign w_unused = &{1'b0, src_addr_i[1:0], byte_len_i[1:0]};

  assign w_free = 14'(FIFO_DEPTH) - 14'(r_count);

`ifdef SGDMAC_RD_4KB_SPLIT_EN
  logic [13:0] w_bound;
  assign w_bound = 14'd1024 - {4'd0, r_addr[11:2]};
`endif

  always_comb begin
    w_blen = r_words_left;
    if (w_blen > 14'(MAX_BURST_LEN)) w_blen = 14'(MAX_BURST_LEN);
`ifdef SGDMAC_RD_4KB_SPLIT_EN
    if (w_blen > w_bound) w_blen = w_bound;
`endif
  end

  // The whole burst is reserved up front, so R beats never need backpressure.
  assign w_space_ok   = (w_free >= w_blen);
  assign w_start      = (r_state == S_IDLE) && start_i;
  assign w_ar_hs      = arvalid_o && arready_i;
  assign w_push       = rready_o && rvalid_i;
  assign data_valid_o = (r_count != '0);
  assign w_pop        = data_valid_o && data_ready_i;
  assign w_drain_done = (r_count == '0) || ((r_count == CW'(1)) && w_pop);

  assign araddr_o    = r_addr;
  assign arlen_o     = (r_state == S_REQ) ? 4'(w_blen - 14'd1) : 4'd0;
  assign arsize_o    = 3'b010;
  assign arburst_o   = 2'b01;
  assign done_o      = r_done;
  assign error_o     = r_error;
  assign data_data_o = r_mem[r_rd_ptr];

  always_comb begin
    w_next    = r_state;
    busy_o    = 1'b0;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = (byte_len_i[15:2] == 14'd0) ? S_DRAIN : S_REQ;
      end
      S_REQ: begin
        busy_o    = 1'b1;
        arvalid_o = w_space_ok;
        if (w_space_ok && arready_i) w_next = S_DATA;
      end
      S_DATA: begin
        busy_o   = 1'b1;
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) w_next = (r_words_left == 14'd0) ? S_DRAIN : S_REQ;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (w_drain_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_addr       <= 32'd0;
      r_words_left <= 14'd0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DRAIN) && w_drain_done;
      if (w_start) begin
        r_addr       <= {src_addr_i[31:2], 2'b00};
        r_words_left <= byte_len_i[15:2];
        r_error      <= 1'b0;
      end else if (w_ar_hs) begin
        r_addr       <= r_addr + {16'd0, w_blen, 2'b00};
        r_words_left <= r_words_left - w_blen;
      end
      if (w_push && (rresp_i != 2'b00)) r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rdata_i;
  end

endmodule

// File: tb/tb_sgdmac_data_reader.sv
// Directed bench for sgdmac_data_reader with a simple AXI read slave returning rdata = beat byte address.
module tb_sgdmac_data_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = 32'd0;
  logic [15:0] byte_len_i = 16'd0;
  logic        busy_o, done_o, error_o, arvalid_o, rready_o, data_valid_o;
  logic [31:0] araddr_o, data_data_o;
  logic [3:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = 32'd0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rlast_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic        data_ready_i = 1'b1;

  always #5 clk = ~clk;

  sgdmac_data_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
    .byte_len_i(byte_len_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_data_o(data_data_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  logic [31:0] ar_addr_q[$];
  logic [3:0]  ar_len_q[$];
  logic [31:0] rx_q[$];
  int   done_cnt = 0, occ = 0, drop_cnt = 0, viol_cnt = 0;
  logic prev_arv = 1'b0, prev_ar_hs = 1'b0, r_hs_s = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0; prev_arv = 1'b0; prev_ar_hs = 1'b0; r_hs_s = 1'b0;
    end else begin
      if (prev_arv && !prev_ar_hs && !arvalid_o) drop_cnt++;
      if (arvalid_o && (occ + int'(arlen_o) + 1 > 16)) viol_cnt++;
      if (arvalid_o && arready_i) begin
        ar_addr_q.push_back(araddr_o);
        ar_len_q.push_back(arlen_o);
      end
      r_hs_s = rvalid_i && rready_o;
      if (data_valid_o && data_ready_i) rx_q.push_back(data_data_o);
      if (done_o) done_cnt++;
      occ = occ + int'(r_hs_s) - int'(data_valid_o && data_ready_i);
      prev_arv = arvalid_o;
      prev_ar_hs = arvalid_o && arready_i;
    end
  end

  // AXI read slave: one burst at a time, optional AR acceptance delay.
  int          s_phase = 0, s_cnt = 0, s_beat = 0, ar_delay = 0;
  logic [31:0] s_addr = 32'd0;
  logic [3:0]  s_len = 4'd0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  task drive_beat();
    rvalid_i = 1'b1;
    rdata_i  = s_addr + 32'(s_beat * 4);
    rresp_i  = (rdata_i == err_addr) ? 2'b10 : 2'b00;
    rlast_i  = (s_beat == int'(s_len));
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      s_phase = 0; s_cnt = 0;
      arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
    end else begin
      case (s_phase)
        0: if (arvalid_o) begin
          if (s_cnt >= ar_delay) begin
            arready_i = 1'b1; s_addr = araddr_o; s_len = arlen_o; s_phase = 1;
          end else s_cnt++;
        end
        1: begin
          arready_i = 1'b0; s_cnt = 0; s_beat = 0; drive_beat(); s_phase = 2;
        end
        default: if (r_hs_s) begin
          if (rlast_i) begin
            rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; s_phase = 0;
          end else begin
            s_beat++; drive_beat();
          end
        end
      endcase
    end
  end

  function automatic logic [31:0] ar_a(input int i);
    return (i < ar_addr_q.size()) ? ar_addr_q[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] ar_l(input int i);
    return (i < ar_len_q.size()) ? 32'(ar_len_q[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] rx_w(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic seg_start(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk); #2;
    start_i = 1'b1; src_addr_i = a; byte_len_i = l;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n = 0;
    while (done_cnt == base && n < 600) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_words(input string tag, input int rb, input logic [31:0] base, input int n);
    chk({tag, " word count"}, 32'(rx_q.size() - rb), 32'(n));
    for (int i = 0; i < n; i++) chk({tag, " word"}, rx_w(rb + i), base + 32'(4 * i));
  endtask

  int ab, rb, db;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst error", 32'(error_o), 32'd0);
    chk("rst arvalid", 32'(arvalid_o), 32'd0);
    chk("rst araddr", araddr_o, 32'd0);
    chk("rst arlen", 32'(arlen_o), 32'd0);
    chk("rst rready", 32'(rready_o), 32'd0);
    chk("rst data_valid", 32'(data_valid_o), 32'd0);
    chk("arsize", 32'(arsize_o), 32'd2);
    chk("arburst", 32'(arburst_o), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;

    // single full burst
    ab = ar_addr_q.size(); rb = rx_q.size(); db = done_cnt;
    seg_start(32'h1000, 16'd64);
    @(negedge clk);
    chk("t1 arvalid after start", 32'(arvalid_o), 32'd1);
    wait_done("t1", db);
    chk("t1 ar count", 32'(ar_addr_q.size() - ab), 32'd1);
    chk("t1 araddr", ar_a(ab), 32'h1000);
    chk("t1 arlen", ar_l(ab), 32'd15);
    check_words("t1", rb, 32'h1000, 16);
    chk("t1 error", 32'(error_o), 32'd0);

    // 16 + 2 beats
    ab = ar_addr_q.size(); rb = rx_q.size(); db = done_cnt;
    seg_start(32'h2000, 16'd72);
    wait_done("t2", db);
    chk("t2 ar count", 32'(ar_addr_q.size() - ab), 32'd2);
    chk("t2 araddr0", ar_a(ab), 32'h2000);
    chk("t2 arlen0", ar_l(ab), 32'd15);
    chk("t2 araddr1", ar_a(ab + 1), 32'h2040);
    chk("t2 arlen1", ar_l(ab + 1), 32'd1);
    check_words("t2", rb, 32'h2000, 18);

    // segment straddling 4 KB
    ab = ar_addr_q.size(); rb = rx_q.size(); db = done_cnt;
    seg_start(32'h0FF8, 16'd64);
    wait_done("t3", db);
`ifdef SGDMAC_RD_4KB_SPLIT_EN
    chk("t3 ar count", 32'(ar_addr_q.size() - ab), 32'd2);
    chk("t3 araddr0", ar_a(ab), 32'h0FF8);
    chk("t3 arlen0", ar_l(ab), 32'd1);
    chk("t3 araddr1", ar_a(ab + 1), 32'h1000);
    chk("t3 arlen1", ar_l(ab + 1), 32'd13);
`else
    chk("t3 ar count", 32'(ar_addr_q.size() - ab), 32'd1);
    chk("t3 araddr0", ar_a(ab), 32'h0FF8);
    chk("t3 arlen0", ar_l(ab), 32'd15);
`endif
    check_words("t3", rb, 32'h0FF8, 16);

    // downstream stalled: FIFO fills, second AR withheld
    ar_delay = 3;
    @(posedge clk); #2 data_ready_i = 1'b0;
    ab = ar_addr_q.size(); rb = rx_q.size(); db = done_cnt;
    seg_start(32'h3000, 16'd128);
    repeat (60) @(negedge clk);
    chk("t4 ar while full", 32'(ar_addr_q.size() - ab), 32'd1);
    chk("t4 arvalid while full", 32'(arvalid_o), 32'd0);
    chk("t4 data_valid while full", 32'(data_valid_o), 32'd1);
    chk("t4 busy while full", 32'(busy_o), 32'd1);
    @(posedge clk); #2 data_ready_i = 1'b1;
    wait_done("t4", db);
    chk("t4 ar count", 32'(ar_addr_q.size() - ab), 32'd2);
    chk("t4 araddr1", ar_a(ab + 1), 32'h3040);
    chk("t4 arlen1", ar_l(ab + 1), 32'd15);
    check_words("t4", rb, 32'h3000, 32);
    chk("t4 arvalid drops", 32'(drop_cnt), 32'd0);
    chk("t4 ar without space", 32'(viol_cnt), 32'd0);
    ar_delay = 0;

    // zero-length segment
    ab = ar_addr_q.size(); db = done_cnt;
    seg_start(32'h8000, 16'd0);
    @(negedge clk);
    chk("t5 busy c1", 32'(busy_o), 32'd1);
    chk("t5 done c1", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("t5 done c2", 32'(done_o), 32'd1);
    chk("t5 busy c2", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("t5 done c3", 32'(done_o), 32'd0);
    chk("t5 ar count", 32'(ar_addr_q.size() - ab), 32'd0);

    // error response is sticky until the next start
    err_addr = 32'h4008;
    rb = rx_q.size(); db = done_cnt;
    seg_start(32'h4000, 16'd16);
    wait_done("t6", db);
    chk("t6 error set", 32'(error_o), 32'd1);
    check_words("t6", rb, 32'h4000, 4);
    err_addr = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("t6 error sticky", 32'(error_o), 32'd1);
    rb = rx_q.size(); db = done_cnt;
    seg_start(32'h5000, 16'd8);
    @(negedge clk);
    chk("t6 error cleared", 32'(error_o), 32'd0);
    wait_done("t6b", db);
    check_words("t6b", rb, 32'h5000, 2);
    chk("t6b error", 32'(error_o), 32'd0);

    // reset in the middle of a data phase
    @(posedge clk); #2 data_ready_i = 1'b0;
    seg_start(32'h6000, 16'd64);
    for (int n = 0; n < 50 && !rready_o; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t7 busy", 32'(busy_o), 32'd0);
    chk("t7 rready", 32'(rready_o), 32'd0);
    chk("t7 arvalid", 32'(arvalid_o), 32'd0);
    chk("t7 data_valid", 32'(data_valid_o), 32'd0);
    chk("t7 done", 32'(done_o), 32'd0);
    chk("t7 araddr", araddr_o, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    data_ready_i = 1'b1;
    ab = ar_addr_q.size(); rb = rx_q.size(); db = done_cnt;
    seg_start(32'h7000, 16'd16);
    wait_done("t7", db);
    chk("t7 ar count", 32'(ar_addr_q.size() - ab), 32'd1);
    chk("t7 araddr", ar_a(ab), 32'h7000);
    chk("t7 arlen", ar_l(ab), 32'd3);
    check_words("t7", rb, 32'h7000, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
